pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multicycle fetch/decode/execute sequencer for the i281 CPU.
- Owns the architectural PC register and produces the branch-select signal c2.
- Computes next PC = PC + 1 + (taken ? offset : 0), mod 2^PC_W.
- Sits between instruction memory, the decoder, the flag register and the datapath enables.

Parameters:
- PC_W, 6: PC and offset width; 64-word instruction space.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching; ignored in every other state.
- mem_ready  input  1  instruction memory word valid at pc this cycle.
- is_branch  input  1  decoded instruction is a branch/jump; sampled in DECODE only.
- branch_cond  input  3  000 JUMP (always), 001 BRE (Z), 010 BRNE (!Z), 011 BRG (!Z & !(N^O)), 100 BRGE (!(N^O)), 101 BRC (C), 110 BRNC (!C), 111 never.
- is_halt  input  1  decoded instruction is HALT; sampled in DECODE.
- offset  input  PC_W  two's-complement branch offset; sampled in DECODE.
- flags  input  4  {C,O,N,Z} from the flag register; sampled in DECODE.
- pc  output  PC_W  current PC; drives instruction memory address.
- ir_load  output  1  load instruction register; one-cycle pulse.
- exec_en  output  1  datapath/flag-register write enable.
- c2  output  1  registered branch-taken decision; valid in EXEC.
- state  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (synchronous, dominates all other inputs, including mid-instruction):
  - state=IDLE, pc=RESET_PC, c2=0, halted=0, ir_load=0, exec_en=0.
  - Internal offset/taken registers cleared.
- IDLE: all enables low. start=1 -> FETCH next cycle.
- FETCH:
  - mem_ready=0: stay in FETCH, ir_load=0 (unbounded wait, no timeout).
  - mem_ready=1: ir_load=1 combinationally in that same cycle, then -> DECODE.
- DECODE (exactly one cycle):
  - Register offset.
  - taken_r <= is_branch & cond(branch_cond, flags).
  - is_halt=1 -> HALT; is_halt has priority over is_branch and PC is unchanged.
  - Otherwise -> EXEC.
- EXEC:
  - exec_en=1 every cycle in EXEC; c2=taken_r.
  - stall is not a port, so EXEC is always exactly one cycle.
  - On exit: pc <= pc + 1 + (taken_r ? sign-extended offset : 0), truncated to PC_W bits (wrap-around, no overflow flag). Then -> FETCH.
- HALT: halted=1, all enables low, pc frozen. Only reset leaves HALT; start is ignored.
- Outputs: c2, pc, state and halted are registered. ir_load and exec_en are Moore/Mealy decodes of state (ir_load also gated by mem_ready).
- Timing:
  - Minimum instruction latency: 3 cycles (FETCH, DECODE, EXEC) with mem_ready held high.
  - pc changes only on the EXEC->FETCH transition and on reset.

Optional Feature:
- Macro PC_BREAKPOINT_EN.
- When defined:
  - Adds ports bp_enable (input, 1) and bp_addr (input, PC_W).
  - On entry evaluation in FETCH, if bp_enable=1 and pc==bp_addr: -> HALT without asserting ir_load, and pc is held.
  - The breakpoint check has priority over mem_ready.
- When undefined: ports absent, no comparison logic, FETCH behaves as above.

Test Plan:
- Reset then start, NOP stream (is_branch=0), mem_ready=1, pc=16 -> after 3 cycles pc=17; ir_load pulses once per 3 cycles; exec_en high only in state 3.
- pc=16, is_branch=1, cond=000, offset=6'b110100 (-12) -> c2=1 in EXEC, next pc=5; same with cond=001 and Z=0 -> c2=0, next pc=17.
- Wrap: pc=63 non-branch -> pc=0; pc=2, JUMP offset=6'b111100 (-4) -> pc=63.
- mem_ready held 0 for 5 cycles in FETCH -> state stays 1, ir_load=0, pc unchanged; mem_ready=1 -> DECODE next cycle.
- is_halt=1 together with is_branch=1 at pc=9 -> HALT, halted=1, pc=9, start ignored; reset mid-EXEC of a taken branch -> pc=RESET_PC, state=0.
- With PC_BREAKPOINT_EN, bp_enable=1, bp_addr=5, jump to 5 -> halts in FETCH at pc=5 with no ir_load pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle FETCH/DECODE/EXEC sequencer for the i281 CPU; owns the PC and the c2 branch select.
// Latency: 3 cycles per instruction minimum (FETCH, DECODE, EXEC); FETCH waits on mem_ready without limit.
// Backpressure: mem_ready low holds FETCH with ir_load low; HALT is left only by reset.
// Optional build macro PC_BREAKPOINT_EN adds bp_enable/bp_addr and a PC breakpoint checked in FETCH.
module pc_sequencer #(
  parameter int unsigned PC_W     = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mem_ready,
  input  logic            is_branch,
  input  logic [2:0]      branch_cond,
  input  logic            is_halt,
  input  logic [PC_W-1:0] offset,
  input  logic [3:0]      flags,
`ifdef PC_BREAKPOINT_EN
  input  logic            bp_enable,
  input  logic [PC_W-1:0] bp_addr,
`endif
  output logic [PC_W-1:0] pc,
  output logic            ir_load,
  output logic            exec_en,
  output logic            c2,
  output logic [2:0]      state,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] offset_r;
  logic            taken_r;
  logic            c2_r;
  logic            halted_r;
  logic            cond_ok;

  // Flags are {C,O,N,Z}; evaluate the branch condition selected by branch_cond.
  always_comb begin
    cond_ok = 1'b0;
    case (branch_cond)
      3'b000:  cond_ok = 1'b1;
      3'b001:  cond_ok = flags[0];
      3'b010:  cond_ok = ~flags[0];
      3'b011:  cond_ok = ~flags[0] & ~(flags[1] ^ flags[2]);
      3'b100:  cond_ok = ~(flags[1] ^ flags[2]);
      3'b101:  cond_ok = flags[3];
      3'b110:  cond_ok = ~flags[3];
      default: cond_ok = 1'b0;
    endcase
  end

  // Next-state decode plus the ir_load / exec_en enables derived from the current state.
  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    exec_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
`ifdef PC_BREAKPOINT_EN
        // A breakpoint hit wins over a ready memory word: stop before loading the IR.
        if (bp_enable && (pc_q == bp_addr)) begin
          state_d = S_HALT;
        end else
`endif
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and the decode-captured branch information; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_W'(RESET_PC);
      offset_r <= '0;
      taken_r  <= 1'b0;
      c2_r     <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_r <= (state_d == S_HALT);
      if (state_q == S_DECODE) begin
        offset_r <= offset;
        taken_r  <= is_branch & cond_ok;
        // c2 is only meaningful in EXEC, so a halting instruction never raises it.
        c2_r     <= is_branch & cond_ok & ~is_halt;
      end
      if (state_q == S_EXEC) begin
        // Modular PC_W-bit add is identical to adding the sign-extended offset and truncating.
        pc_q <= pc_q + PC_W'(1) + (taken_r ? offset_r : '0);
        c2_r <= 1'b0;
      end
    end
  end

  assign pc     = pc_q;
  assign c2     = c2_r;
  assign state  = state_q;
  assign halted = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed i281 scenarios followed by randomized instruction streams.
// Expected EXEC/HALT events are queued at issue and checked by an independent output monitor.
// Define PC_BREAKPOINT_EN for both RTL and bench to exercise the breakpoint path.
module tb_pc_sequencer;

  localparam int PC_W = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mem_ready = 1'b0;
  logic       is_branch = 1'b0;
  logic [2:0] branch_cond = 3'd0;
  logic       is_halt = 1'b0;
  logic [5:0] offset = 6'd0;
  logic [3:0] flags = 4'd0;
`ifdef PC_BREAKPOINT_EN
  logic       bp_enable = 1'b0;
  logic [5:0] bp_addr = 6'd0;
`endif
  logic [5:0] pc;
  logic       ir_load;
  logic       exec_en;
  logic       c2;
  logic [2:0] state;
  logic       halted;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
    .is_branch(is_branch), .branch_cond(branch_cond), .is_halt(is_halt),
    .offset(offset), .flags(flags),
`ifdef PC_BREAKPOINT_EN
    .bp_enable(bp_enable), .bp_addr(bp_addr),
`endif
    .pc(pc), .ir_load(ir_load), .exec_en(exec_en), .c2(c2),
    .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_halt_ev;
    int pc;
    bit c2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_pc = 0;
  int   n_ir = 0;
  int   n_exp_ir = 0;
  bit   prev_halted = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Branch rules straight from the ISA table; f = {C,O,N,Z}.
  function automatic bit cond_fn(input bit [2:0] c, input bit [3:0] f);
    bit cf, of, nf, zf;
    cf = f[3]; of = f[2]; nf = f[1]; zf = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return zf;
      3'd2: return !zf;
      3'd3: return !zf && (nf == of);
      3'd4: return nf == of;
      3'd5: return cf;
      3'd6: return !cf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int next_pc(input int cur, input bit taken, input bit [5:0] off);
    int o;
    o = (off >= 32) ? int'(off) - 64 : int'(off);
    if (!taken) o = 0;
    return (((cur + 1 + o) % 64) + 64) % 64;
  endfunction

  // Output monitor: consumes queued expectations whenever the DUT executes or halts.
  always @(negedge clk) begin
    exp_t e;
    if (exec_en) begin
      if (exp_q.size() == 0) begin
        chk("exec_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("exec_kind", 0, int'(e.is_halt_ev));
        chk("exec_pc", int'(pc), e.pc);
        chk("exec_c2", int'(c2), int'(e.c2));
        chk("exec_state", int'(state), 3);
      end
    end
    if (halted && !prev_halted) begin
      if (exp_q.size() == 0) begin
        chk("halt_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("halt_kind", 1, int'(e.is_halt_ev));
        chk("halt_pc", int'(pc), e.pc);
        chk("halt_state", int'(state), 4);
      end
    end
    if (ir_load) begin
      n_ir++;
      chk("ir_load_ctx", int'({state, mem_ready}), int'({3'd1, 1'b1}));
    end
    prev_halted = halted;
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_outs", int'({c2, halted, ir_load, exec_en}), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One instruction from FETCH: k stall cycles, accept, DECODE, then EXEC (or HALT).
  task automatic run_instr(input int k, input bit br, input bit [2:0] cond, input bit [3:0] fl,
                           input bit [5:0] off, input bit hlt, input bit rst_exec);
    exp_t e;
    bit   taken;
    is_branch = br; branch_cond = cond; flags = fl; offset = off; is_halt = hlt;
    taken = br && cond_fn(cond, fl);
    e.is_halt_ev = hlt;
    e.pc = m_pc;
    e.c2 = hlt ? 1'b0 : taken;
    exp_q.push_back(e);
    n_exp_ir++;
    for (int i = 0; i < k; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("stall_state", int'(state), 1);
      chk("stall_ir_load", int'(ir_load), 0);
      chk("stall_pc", int'(pc), m_pc);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    if (hlt) return;
    if (rst_exec) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_pc = 0;
      #1;
      chk("rst_exec_state", int'(state), 0);
      chk("rst_exec_pc", int'(pc), 0);
      return;
    end
    @(posedge clk); #1;
    m_pc = next_pc(m_pc, taken, off);
  endtask

  // While halted, start must be ignored and the PC frozen.
  task automatic halt_hold();
    start = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("halt_hold_state", int'(state), 4);
      chk("halt_hold_halted", int'(halted), 1);
      chk("halt_hold_pc", int'(pc), m_pc);
      chk("halt_hold_en", int'({ir_load, exec_en}), 0);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hlt;
    bit rx;
    @(posedge clk); #1;
    do_reset();
    do_start();
    repeat (16) run_instr(0, 0, 3'd0, 4'd0, 6'd0, 0, 0);
    chk("nop_pc16", int'(pc), 16);
    run_instr(0, 1, 3'd0, 4'd0, 6'b110100, 0, 0);   // 16 -> 5
    run_instr(0, 1, 3'd0, 4'd0, 6'd10, 0, 0);       // 5 -> 16
    run_instr(0, 1, 3'd1, 4'd0, 6'b110100, 0, 0);   // BRE not taken: 16 -> 17
    run_instr(1, 1, 3'd0, 4'd0, 6'b101101, 0, 0);   // 17 -> 63
    run_instr(0, 0, 3'd0, 4'd0, 6'd0, 0, 0);        // 63 -> 0
    chk("wrap_pc0", int'(pc), 0);
    repeat (2) run_instr(0, 0, 3'd0, 4'd0, 6'd0, 0, 0);
    run_instr(0, 1, 3'd0, 4'd0, 6'b111100, 0, 0);   // 2 -> 63
    chk("wrap_pc63", int'(pc), 63);
    run_instr(5, 0, 3'd0, 4'd0, 6'd0, 0, 0);        // stalled fetch, 63 -> 0
    run_instr(0, 1, 3'd0, 4'd0, 6'd8, 0, 0);        // 0 -> 9
    run_instr(0, 1, 3'd0, 4'd0, 6'b110100, 1, 0);   // halt beats branch at 9
    halt_hold();
    do_reset();
    do_start();
    run_instr(0, 1, 3'd0, 4'd0, 6'd3, 0, 1);        // reset during taken-branch EXEC
`ifdef PC_BREAKPOINT_EN
    begin
      exp_t e;
      do_start();
      bp_addr = 6'd5;
      bp_enable = 1'b1;
      run_instr(0, 1, 3'd0, 4'd0, 6'd4, 0, 0);      // 0 -> 5
      mem_ready = 1'b1;
      e.is_halt_ev = 1'b1; e.pc = 5; e.c2 = 1'b0;
      exp_q.push_back(e);
      #1;
      chk("bp_no_ir_load", int'(ir_load), 0);
      @(posedge clk); #1;
      chk("bp_state", int'(state), 4);
      chk("bp_pc", int'(pc), 5);
      bp_enable = 1'b0;
      do_reset();
    end
`endif
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      do_start();
      for (int n = 0; n < 25; n++) begin
        hlt = ($urandom_range(0, 19) == 0);
        rx  = !hlt && ($urandom_range(0, 29) == 0);
        run_instr(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), hlt, rx);
        if (hlt) begin
          halt_hold();
          break;
        end
        if (rx) do_start();
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("ir_load_count", n_ir, n_exp_ir);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
